// File: rtl/rams64_pkg.sv
// rams64_pkg: shared types, widths and bit-placement helper for the 64x1 RAM readback sequencer.
package rams64_pkg;
    localparam int RAM_DEPTH = 64;
    localparam int ADR_W = 6;
    localparam int BYTE_W = 8;

    typedef enum logic [2:0] {IDLE, FETCH, PRESENT, CSUM, FIN} state_e;

    function automatic logic [2:0] bit_pos(input logic lsb_first, input logic [2:0] cnt);
        return lsb_first ? cnt : 3'd7 - cnt;
    endfunction
endpackage

// File: rtl/rams64_readback_bit_packer.sv
// rams64_bit_packer: assembles eight serial RAM bits into a byte; load_o flags the eighth bit,
// with byte_o already holding that bit so the caller can capture the byte on the same edge.
module rams64_bit_packer
    import rams64_pkg::*;
#(
    parameter int LSB_FIRST = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr_i,
    input  logic              shift_i,
    input  logic              bit_i,
    output logic [BYTE_W-1:0] byte_o,
    output logic              load_o
);
    logic [BYTE_W-1:0] sh_q, sh_d;
    logic [2:0]        cnt_q;

    always_comb begin
        sh_d = sh_q;
        sh_d[bit_pos(LSB_FIRST != 0, cnt_q)] = bit_i;
    end

    assign byte_o = sh_d;
    assign load_o = shift_i && cnt_q == 3'd7;

    always_ff @(posedge clk) begin
        if (rst || clr_i) begin
            sh_q  <= '0;
            cnt_q <= '0;
        end else if (shift_i) begin
            sh_q  <= sh_d;
            cnt_q <= cnt_q + 3'd1;
        end
    end
endmodule

// File: rtl/rams64_readback.sv
// rams64_readback: sweeps a 64x1 distributed RAM and streams its contents as bytes.
// Optional macro READBACK_CSUM_EN appends an XOR checksum byte to each sweep.
module rams64_readback
    import rams64_pkg::*;
#(
    parameter int START_ADR = 0,
    parameter int NUM_BITS  = 64,
    parameter int LSB_FIRST = 1
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              START,
    output logic [ADR_W-1:0]  RAM_ADR,
    input  logic              RAM_O,
    output logic              WE_ALLOW,
    output logic [BYTE_W-1:0] DOUT,
    output logic              DOUT_VALID,
    input  logic              DOUT_READY,
    output logic              DOUT_LAST,
    output logic              BUSY,
    output logic              DONE
);
    localparam logic [ADR_W-1:0] ADR0 = START_ADR[ADR_W-1:0];
    localparam logic [2:0] LAST_BYTE = 3'(NUM_BITS / 8 - 1);

    state_e            state_q, state_d;
    logic [ADR_W-1:0]  adr_q, adr_d;
    logic [BYTE_W-1:0] dout_q, dout_d;
    logic              valid_q, valid_d, last_q, last_d, busy_q, busy_d, done_q, done_d;
    logic [2:0]        byte_q, byte_d;
    logic [BYTE_W-1:0] pk_byte;
    logic              pk_load;
`ifdef READBACK_CSUM_EN
    logic [BYTE_W-1:0] csum_q, csum_d;
`endif

    rams64_bit_packer #(.LSB_FIRST(LSB_FIRST)) u_packer (
        .clk     (CLK),
        .rst     (RST),
        .clr_i   (state_q == IDLE && START),
        .shift_i (state_q == FETCH),
        .bit_i   (RAM_O),
        .byte_o  (pk_byte),
        .load_o  (pk_load)
    );

    always_comb begin
        state_d = state_q;
        adr_d   = adr_q;
        dout_d  = dout_q;
        valid_d = valid_q;
        last_d  = last_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        byte_d  = byte_q;
`ifdef READBACK_CSUM_EN
        csum_d  = csum_q;
`endif
        case (state_q)
            IDLE: if (START) begin
                state_d = FETCH;
                adr_d   = ADR0;
                byte_d  = '0;
                busy_d  = 1'b1;
`ifdef READBACK_CSUM_EN
                csum_d  = '0;
`endif
            end
            FETCH: begin
                adr_d = adr_q + 6'd1;
                if (pk_load) begin
                    state_d = PRESENT;
                    dout_d  = pk_byte;
                    valid_d = 1'b1;
`ifdef READBACK_CSUM_EN
                    last_d  = 1'b0;
                    csum_d  = csum_q ^ pk_byte;
`else
                    last_d  = byte_q == LAST_BYTE;
`endif
                end
            end
            PRESENT: if (valid_q && DOUT_READY) begin
                valid_d = 1'b0;
                last_d  = 1'b0;
                if (byte_q == LAST_BYTE) begin
`ifdef READBACK_CSUM_EN
                    // checksum byte goes out on the same edge that retires the last data byte
                    state_d = CSUM;
                    dout_d  = csum_q;
                    valid_d = 1'b1;
                    last_d  = 1'b1;
`else
                    state_d = FIN;
`endif
                end else begin
                    byte_d  = byte_q + 3'd1;
                    state_d = FETCH;
                end
            end
`ifdef READBACK_CSUM_EN
            CSUM: if (valid_q && DOUT_READY) begin
                valid_d = 1'b0;
                last_d  = 1'b0;
                state_d = FIN;
            end
`endif
            FIN: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                adr_d   = ADR0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            adr_q   <= ADR0;
            dout_q  <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            byte_q  <= '0;
`ifdef READBACK_CSUM_EN
            csum_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            adr_q   <= adr_d;
            dout_q  <= dout_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            byte_q  <= byte_d;
`ifdef READBACK_CSUM_EN
            csum_q  <= csum_d;
`endif
        end
    end

    assign RAM_ADR    = adr_q;
    assign DOUT       = dout_q;
    assign DOUT_VALID = valid_q;
    assign DOUT_LAST  = last_q;
    assign BUSY       = busy_q;
    assign DONE       = done_q;
    assign WE_ALLOW   = ~busy_q;
endmodule

// File: tb/tb_rams64_readback.sv
// tb_rams64_readback: directed checks of the readback sequencer on three parameterisations.
module tb_rams64_readback;
`ifdef READBACK_CSUM_EN
    localparam int CS = 1;
`else
    localparam int CS = 0;
`endif
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    logic [63:0] ram0 = 64'h0123456789ABCDEF;
    logic [63:0] ram1 = 64'hA000000000000005;
    logic [7:0]  exp0 [0:8] = '{8'hEF, 8'hCD, 8'hAB, 8'h89, 8'h67, 8'h45, 8'h23, 8'h01, 8'h00};

    logic start0, ready0, we0, v0, l0, b0, d0;
    logic start1, ready1, we1, v1, l1, b1, d1;
    logic start2, ready2, we2, v2, l2, b2, d2;
    logic [5:0] a0, a1, a2;
    logic [7:0] q0, q1, q2;

    rams64_readback u0 (
        .CLK(clk), .RST(rst), .START(start0), .RAM_ADR(a0), .RAM_O(ram0[a0]), .WE_ALLOW(we0),
        .DOUT(q0), .DOUT_VALID(v0), .DOUT_READY(ready0), .DOUT_LAST(l0), .BUSY(b0), .DONE(d0)
    );
    rams64_readback #(.START_ADR(60), .NUM_BITS(8)) u1 (
        .CLK(clk), .RST(rst), .START(start1), .RAM_ADR(a1), .RAM_O(ram1[a1]), .WE_ALLOW(we1),
        .DOUT(q1), .DOUT_VALID(v1), .DOUT_READY(ready1), .DOUT_LAST(l1), .BUSY(b1), .DONE(d1)
    );
    rams64_readback #(.NUM_BITS(16), .LSB_FIRST(0)) u2 (
        .CLK(clk), .RST(rst), .START(start2), .RAM_ADR(a2), .RAM_O(ram0[a2]), .WE_ALLOW(we2),
        .DOUT(q2), .DOUT_VALID(v2), .DOUT_READY(ready2), .DOUT_LAST(l2), .BUSY(b2), .DONE(d2)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic sweep0(input int stall_len, input bit extra);
        int nb, dn, done_at, first_v, st, done_exp;
        bit we_ok, held;
        nb = 0; dn = 0; done_at = -1; first_v = -1; st = 0; we_ok = 1; held = 1;
        done_exp = 73 + CS + stall_len;
        ready0 = 1'b1;
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        for (int c = 1; c <= 110; c++) begin
            start0 = extra && (c == 20 || c == done_exp);
            tick();
            start0 = 1'b0;
            if (c < done_exp && we0 !== 1'b0) we_ok = 0;
            if (d0) begin
                dn++;
                done_at = c;
            end
            if (v0) begin
                if (first_v < 0) first_v = c;
                if (nb == 2 && st < stall_len) begin
                    ready0 = 1'b0;
                    st++;
                    if (q0 !== 8'hAB || a0 !== 6'd24) held = 0;
                end else begin
                    ready0 = 1'b1;
                    chk($sformatf("byte%0d", nb), 32'(q0), 32'(nb < 9 ? exp0[nb] : 8'hxx));
                    chk($sformatf("last%0d", nb), 32'(l0), 32'(CS != 0 ? nb == 8 : nb == 7));
                    nb++;
                end
            end
        end
        ready0 = 1'b1;
        chk("first_valid_cycle", 32'(first_v), 32'd8);
        chk("byte_count", 32'(nb), 32'(8 + CS));
        chk("done_count", 32'(dn), 32'd1);
        chk("done_cycle", 32'(done_at), 32'(done_exp));
        chk("we_allow_low_while_busy", 32'(we_ok), 32'd1);
        if (stall_len > 0) chk("stall_hold", 32'(held), 32'd1);
        chk("busy_after", 32'(b0), 32'd0);
        chk("adr_after", 32'(a0), 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        {start0, start1, start2} = '0;
        {ready0, ready1, ready2} = '1;
        repeat (3) tick();
        chk("rst_adr0", 32'(a0), 32'd0);
        chk("rst_adr1", 32'(a1), 32'd60);
        chk("rst_dout", 32'(q0), 32'd0);
        chk("rst_valid", 32'(v0), 32'd0);
        chk("rst_last", 32'(l0), 32'd0);
        chk("rst_busy", 32'(b0), 32'd0);
        chk("rst_done", 32'(d0), 32'd0);
        chk("rst_we", 32'(we0), 32'd1);
        rst = 1'b0;
        tick();

        sweep0(0, 1'b0);
        sweep0(5, 1'b0);
        sweep0(0, 1'b1);

        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        repeat (29) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_valid", 32'(v0), 32'd0);
        chk("midrst_busy", 32'(b0), 32'd0);
        chk("midrst_we", 32'(we0), 32'd1);
        chk("midrst_done", 32'(d0), 32'd0);
        chk("midrst_adr", 32'(a0), 32'd0);
        begin
            int dn = 0;
            repeat (60) begin
                tick();
                if (d0 || v0) dn++;
            end
            chk("midrst_quiet", 32'(dn), 32'd0);
        end
        rst = 1'b1;
        start0 = 1'b1;
        tick();
        rst = 1'b0;
        start0 = 1'b0;
        tick();
        chk("start_with_rst_ignored", 32'(b0), 32'd0);
        sweep0(0, 1'b0);

        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            chk($sformatf("wrap_adr%0d", c), 32'(a1), 32'((60 + c - 1) % 64));
            tick();
        end
        chk("wrap_valid", 32'(v1), 32'd1);
        chk("wrap_dout", 32'(q1), 32'h5A);
        chk("wrap_last", 32'(l1), 32'(CS == 0));
        tick();
        if (CS != 0) begin
            chk("wrap_csum", 32'(q1), 32'h5A);
            chk("wrap_csum_last", 32'(l1 & v1), 32'd1);
            tick();
        end
        tick();
        chk("wrap_done", 32'(d1), 32'd1);
        chk("wrap_busy", 32'(b1), 32'd0);
        chk("wrap_adr_home", 32'(a1), 32'd60);

        start2 = 1'b1;
        tick();
        start2 = 1'b0;
        repeat (7) tick();
        chk("msb_not_yet_valid", 32'(v2), 32'd0);
        tick();
        chk("msb_byte0", 32'(q2), 32'hF7);
        chk("msb_last0", 32'(l2), 32'd0);
        repeat (9) tick();
        chk("msb_byte1", 32'(q2), 32'hB3);
        chk("msb_last1", 32'(l2), 32'(CS == 0));
        tick();
        if (CS != 0) begin
            chk("msb_csum", 32'(q2), 32'h44);
            chk("msb_csum_last", 32'(l2 & v2), 32'd1);
            tick();
        end
        tick();
        chk("msb_done", 32'(d2), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
